// File: rtl/pipe_dp_pkg.sv
// Shared types, decode constants and the combinational ALU for the pipelined
// integer datapath.
package pipe_dp_pkg;

  // Storage width for stage fields; modules truncate to their own XLEN/AW.
  localparam int XLEN_MAX = 64;
  localparam int AW_MAX   = 16;

  localparam logic [4:0] OP     = 5'b01100;
  localparam logic [4:0] OP_IMM = 5'b00100;
  localparam logic [4:0] LUI    = 5'b01101;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASSB
  } alu_op_e;

  typedef struct packed {
    logic                valid;
    logic                we;
    logic                illegal;
    logic [AW_MAX-1:0]   rd;
    alu_op_e             alu_op;
    logic [XLEN_MAX-1:0] a;
    logic [XLEN_MAX-1:0] b;
  } ex_stage_t;

  // alt is funct7[5]; it selects SUB only for register-register ops.
  function automatic alu_op_e decode_alu_op(input logic [4:0] opcode,
                                            input logic [2:0] func3,
                                            input logic       alt);
    alu_op_e op;
    op = ALU_PASSB;
    if (opcode == OP || opcode == OP_IMM) begin
      case (func3)
        F3_ADD:  op = (opcode == OP && alt) ? ALU_SUB : ALU_ADD;
        F3_SLL:  op = ALU_SLL;
        F3_SLT:  op = ALU_SLT;
        F3_SLTU: op = ALU_SLTU;
        F3_XOR:  op = ALU_XOR;
        F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
        F3_OR:   op = ALU_OR;
        default: op = ALU_AND;
      endcase
    end
    return op;
  endfunction

  // Operands arrive zero-extended from xlen bits; signed views are rebuilt
  // here, and the caller keeps only the low xlen bits of the result.
  function automatic logic [XLEN_MAX-1:0] alu(input alu_op_e             op,
                                              input logic [XLEN_MAX-1:0] a,
                                              input logic [XLEN_MAX-1:0] b,
                                              input int unsigned         xlen,
                                              input logic [5:0]          sh_mask);
    logic signed [XLEN_MAX-1:0] sa;
    logic signed [XLEN_MAX-1:0] sb;
    logic [6:0]                 pad;
    logic [5:0]                 shamt;
    logic [XLEN_MAX-1:0]        res;
    pad   = 7'(XLEN_MAX - xlen);
    sa    = $signed(a << pad) >>> pad;
    sb    = $signed(b << pad) >>> pad;
    shamt = b[5:0] & sh_mask;
    case (op)
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_SLL:  res = a << shamt;
      ALU_SLT:  res = {{(XLEN_MAX-1){1'b0}}, sa < sb};
      ALU_SLTU: res = {{(XLEN_MAX-1){1'b0}}, a < b};
      ALU_XOR:  res = a ^ b;
      ALU_SRL:  res = a >> shamt;
      ALU_SRA:  res = sa >>> shamt;
      ALU_OR:   res = a | b;
      ALU_AND:  res = a & b;
      default:  res = b;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pipe_datapath_reg_file.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, register 0 reads as zero and ignores writes.
module reg_file_p #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [NREGS];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  // NOTE: this array is reset because architectural state must read as zero
  // after reset; that forces flops rather than a RAM macro.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/pipe_datapath.sv
// Pipelined integer datapath: issue (operand read + bypass), EX register
// (ALU evaluated from it), WB register driving the result port and write-back.
module pipe_datapath
  import pipe_dp_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rd,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic [4:0]      in_opcode,
  input  logic [2:0]      in_func3,
  input  logic [6:0]      in_func7,
  input  logic [XLEN-1:0] in_imm,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [AW-1:0]   res_rd,
  output logic [XLEN-1:0] res_data,
  output logic            res_illegal
);

  localparam logic [5:0] SH_MASK = 6'((1 << $clog2(XLEN)) - 1);

  ex_stage_t           ex_q;
  ex_stage_t           ex_d;
  logic                wb_valid;
  logic                wb_we;
  logic                wb_illegal;
  logic [AW-1:0]       wb_rd;
  logic [XLEN-1:0]     wb_data;

  logic                wb_adv;
  logic                ex_adv;
  logic                accept;
  logic                rf_we;
  logic [XLEN-1:0]     rf_rd1;
  logic [XLEN-1:0]     rf_rd2;
  logic [XLEN-1:0]     op_a;
  logic [XLEN-1:0]     op_rs2;
  logic [XLEN_MAX-1:0] ex_res_full;
  logic [XLEN-1:0]     ex_res;
  logic                ex_hit1;
  logic                ex_hit2;
  logic                wb_hit1;
  logic                wb_hit2;

  // Only funct7[5] carries meaning for the supported instructions.
  logic unused_func7;
  assign unused_func7 = ^{in_func7[6], in_func7[4:0]};

  assign wb_adv   = !wb_valid || res_ready;
  assign ex_adv   = !ex_q.valid || wb_adv;
  assign in_ready = ex_adv;
  assign accept   = in_valid && ex_adv;
  assign rf_we    = wb_valid && res_ready && wb_we;

  assign ex_res_full = alu(ex_q.alu_op, ex_q.a, ex_q.b, XLEN, SH_MASK);
  assign ex_res      = XLEN'(ex_res_full);

  reg_file_p #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_rf (
    .clock  (clock),
    .reset  (reset),
    .we     (rf_we),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (in_rs1),
    .rdata1 (rf_rd1),
    .raddr2 (in_rs2),
    .rdata2 (rf_rd2)
  );

  // The youngest producer wins; WB data also covers a write landing this edge.
  assign ex_hit1 = in_rs1 != '0 && ex_q.valid && ex_q.we && AW'(ex_q.rd) == in_rs1;
  assign ex_hit2 = in_rs2 != '0 && ex_q.valid && ex_q.we && AW'(ex_q.rd) == in_rs2;
  assign wb_hit1 = in_rs1 != '0 && wb_valid && wb_we && wb_rd == in_rs1;
  assign wb_hit2 = in_rs2 != '0 && wb_valid && wb_we && wb_rd == in_rs2;

  assign op_a   = ex_hit1 ? ex_res : (wb_hit1 ? wb_data : rf_rd1);
  assign op_rs2 = ex_hit2 ? ex_res : (wb_hit2 ? wb_data : rf_rd2);

  // NOTE: every field gets a default before the case so no path leaves a
  // variable unassigned and infers a latch.
  always_comb begin
    ex_d        = '0;
    ex_d.valid  = 1'b1;
    ex_d.rd     = AW_MAX'(in_rd);
    ex_d.alu_op = decode_alu_op(in_opcode, in_func3, in_func7[5]);
    ex_d.a      = XLEN_MAX'(op_a);
    case (in_opcode)
      OP: begin
        ex_d.we = 1'b1;
        ex_d.b  = XLEN_MAX'(op_rs2);
      end
      OP_IMM, LUI: begin
        ex_d.we = 1'b1;
        ex_d.b  = XLEN_MAX'(in_imm);
      end
      default: begin
        // PASSB of a zero b yields the required zero result.
        ex_d.illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_q <= '0;
    end else if (ex_adv) begin
      if (accept) ex_q <= ex_d;
      else        ex_q.valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_illegal <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
    end else if (wb_adv) begin
      wb_valid <= ex_q.valid;
      if (ex_q.valid) begin
        wb_we      <= ex_q.we;
        wb_illegal <= ex_q.illegal;
        wb_rd      <= AW'(ex_q.rd);
        wb_data    <= ex_res;
      end
    end
  end

  assign res_valid   = wb_valid;
  assign res_rd      = wb_rd;
  assign res_data    = wb_data;
  assign res_illegal = wb_illegal;

endmodule
